// File: rtl/csr_ex_stage.sv
// rtl/csr_ex_stage.sv - EX/WB pipeline stage between the decoder and the CSR register file
// Drives the file read port in EX and write port in WB, returns the old CSR value, counts retired ops.
module csr_ex_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [2:0]       id_csr_type,
  input  logic [4:0]       id_csr_addr,
  input  logic [4:0]       id_rs1_addr,
  input  logic [31:0]      id_rs1_data,
  input  logic [4:0]       id_zimm,
  input  logic [4:0]       id_rd,
  output logic             csr_read_en,
  output logic [4:0]       csr_r_addr,
  input  logic [31:0]      csr_rdata,
  output logic             csr_write_en,
  output logic [4:0]       csr_w_addr,
  output logic [2:0]       csr_type,
  output logic [31:0]      csr_in_data,
  output logic [31:0]      csr_imm,
  output logic             wb_rd_en,
  output logic [4:0]       wb_rd_addr,
  output logic [31:0]      wb_rd_data,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [2:0] CSRRW  = 3'd1;
  localparam logic [2:0] CSRRS  = 3'd2;
  localparam logic [2:0] CSRRC  = 3'd3;
  localparam logic [2:0] CSRRWI = 3'd5;
  localparam logic [2:0] CSRRSI = 3'd6;
  localparam logic [2:0] CSRRCI = 3'd7;

  logic             r_ex_valid;
  logic [2:0]       r_ex_type;
  logic [4:0]       r_ex_addr;
  logic [4:0]       r_ex_rs1_addr;
  logic [31:0]      r_ex_rs1_data;
  logic [4:0]       r_ex_zimm;
  logic [4:0]       r_ex_rd;

  logic             r_wb_valid;
  logic [2:0]       r_wb_type;
  logic [4:0]       r_wb_addr;
  logic [4:0]       r_wb_rs1_addr;
  logic [31:0]      r_wb_rs1_data;
  logic [4:0]       r_wb_zimm;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_rdata;
  logic [CNT_W-1:0] r_retired_cnt;

  logic             w_ex_read;
  logic             w_wb_type_ok;
  logic             w_wb_legal;
  logic             w_wb_write;

  // Swap ops that discard the old value skip the read entirely.
  assign w_ex_read = r_ex_valid &&
                     !(((r_ex_type == CSRRW) || (r_ex_type == CSRRWI)) && (r_ex_rd == 5'd0));

  assign w_wb_type_ok = (r_wb_type == CSRRW)  || (r_wb_type == CSRRS)  || (r_wb_type == CSRRC) ||
                        (r_wb_type == CSRRWI) || (r_wb_type == CSRRSI) || (r_wb_type == CSRRCI);
  assign w_wb_legal   = r_wb_valid && w_wb_type_ok && (r_wb_addr != 5'd0);

  // Set/clear with a zero source is a pure read and must not write.
  assign w_wb_write = w_wb_legal &&
                      !(((r_wb_type == CSRRS)  || (r_wb_type == CSRRC))  && (r_wb_rs1_addr == 5'd0)) &&
                      !(((r_wb_type == CSRRSI) || (r_wb_type == CSRRCI)) && (r_wb_zimm == 5'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_type     <= 3'd0;
      r_ex_addr     <= 5'd0;
      r_ex_rs1_addr <= 5'd0;
      r_ex_rs1_data <= 32'd0;
      r_ex_zimm     <= 5'd0;
      r_ex_rd       <= 5'd0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (!stall) begin
      r_ex_valid    <= id_valid;
      r_ex_type     <= id_csr_type;
      r_ex_addr     <= id_csr_addr;
      r_ex_rs1_addr <= id_rs1_addr;
      r_ex_rs1_data <= id_rs1_data;
      r_ex_zimm     <= id_zimm;
      r_ex_rd       <= id_rd;
    end
  end

  // WB copies EX every edge; only the valid bit decides whether it counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid    <= 1'b0;
      r_wb_type     <= 3'd0;
      r_wb_addr     <= 5'd0;
      r_wb_rs1_addr <= 5'd0;
      r_wb_rs1_data <= 32'd0;
      r_wb_zimm     <= 5'd0;
      r_wb_rd       <= 5'd0;
      r_wb_rdata    <= 32'd0;
    end else begin
      r_wb_valid    <= r_ex_valid & ~stall & ~flush;
      r_wb_type     <= r_ex_type;
      r_wb_addr     <= r_ex_addr;
      r_wb_rs1_addr <= r_ex_rs1_addr;
      r_wb_rs1_data <= r_ex_rs1_data;
      r_wb_zimm     <= r_ex_zimm;
      r_wb_rd       <= r_ex_rd;
      r_wb_rdata    <= w_ex_read ? csr_rdata : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired_cnt <= '0;
    end else if (w_wb_legal) begin
      r_retired_cnt <= r_retired_cnt + 1'b1;
    end
  end

  always_comb begin
    csr_read_en  = w_ex_read;
    csr_r_addr   = r_ex_valid ? r_ex_addr : 5'd0;
    csr_write_en = w_wb_write;
    csr_w_addr   = 5'd0;
    csr_type     = 3'd0;
    csr_in_data  = 32'd0;
    csr_imm      = 32'd0;
    wb_rd_en     = 1'b0;
    wb_rd_addr   = 5'd0;
    wb_rd_data   = 32'd0;
    illegal      = r_wb_valid & ~w_wb_legal;
    retired_cnt  = r_retired_cnt;
    if (w_wb_legal) begin
      csr_w_addr  = r_wb_addr;
      csr_type    = r_wb_type;
      csr_in_data = r_wb_rs1_data;
      csr_imm     = {27'd0, r_wb_zimm};
      wb_rd_en    = (r_wb_rd != 5'd0);
      wb_rd_addr  = r_wb_rd;
      wb_rd_data  = r_wb_rdata;
    end
  end

endmodule

// File: tb/tb_csr_ex_stage.sv
// tb/tb_csr_ex_stage.sv - directed vector bench for csr_ex_stage with a falling-edge CSR file model
// Table of single-edge vectors plus hand sequences for stall, flush, reset and counter wrap.
module tb_csr_ex_stage;

  localparam int CW = 4;
  localparam logic [2:0] W = 3'd1, S = 3'd2, CI = 3'd7, WI = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0, flush = 1'b0;
  logic          id_valid = 1'b0;
  logic [2:0]    id_csr_type = '0;
  logic [4:0]    id_csr_addr = '0, id_rs1_addr = '0, id_zimm = '0, id_rd = '0;
  logic [31:0]   id_rs1_data = '0;
  logic          csr_read_en, csr_write_en, wb_rd_en, illegal;
  logic [4:0]    csr_r_addr, csr_w_addr, wb_rd_addr;
  logic [2:0]    csr_type;
  logic [31:0]   csr_rdata, csr_in_data, csr_imm, wb_rd_data;
  logic [CW-1:0] retired_cnt;

  logic [31:0]   csr_file [32];
  int            n_writes = 0;
  int            n_vec = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  csr_ex_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_csr_type(id_csr_type), .id_csr_addr(id_csr_addr),
    .id_rs1_addr(id_rs1_addr), .id_rs1_data(id_rs1_data), .id_zimm(id_zimm), .id_rd(id_rd),
    .csr_read_en(csr_read_en), .csr_r_addr(csr_r_addr), .csr_rdata(csr_rdata),
    .csr_write_en(csr_write_en), .csr_w_addr(csr_w_addr), .csr_type(csr_type),
    .csr_in_data(csr_in_data), .csr_imm(csr_imm),
    .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .illegal(illegal), .retired_cnt(retired_cnt)
  );

  assign csr_rdata = csr_file[csr_r_addr];

  always @(negedge clk) begin
    if (csr_write_en) begin
      n_writes = n_writes + 1;
      case (csr_type)
        3'd1: csr_file[csr_w_addr] = csr_in_data;
        3'd2: csr_file[csr_w_addr] = csr_file[csr_w_addr] | csr_in_data;
        3'd3: csr_file[csr_w_addr] = csr_file[csr_w_addr] & ~csr_in_data;
        3'd5: csr_file[csr_w_addr] = csr_imm;
        3'd6: csr_file[csr_w_addr] = csr_file[csr_w_addr] | csr_imm;
        3'd7: csr_file[csr_w_addr] = csr_file[csr_w_addr] & ~csr_imm;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic          v;
    logic [2:0]    t;
    logic [4:0]    a, r1a;
    logic [31:0]   r1d;
    logic [4:0]    z, rd;
    logic          e_ren;
    logic [4:0]    e_ra;
    logic          e_wen;
    logic [4:0]    e_wa;
    logic [31:0]   e_in, e_imm;
    logic          e_rden;
    logic [4:0]    e_rda;
    logic [31:0]   e_rdd;
    logic          e_ill;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] t, input logic [4:0] a, input logic [4:0] r1a,
                        input logic [31:0] r1d, input logic [4:0] z, input logic [4:0] rd);
    id_valid = v; id_csr_type = t; id_csr_addr = a; id_rs1_addr = r1a;
    id_rs1_data = r1d; id_zimm = z; id_rd = rd;
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] t, input logic [4:0] a, input logic [4:0] r1a,
                              input logic [31:0] r1d, input logic [4:0] z, input logic [4:0] rd,
                              input logic e_ren, input logic [4:0] e_ra, input logic e_wen, input logic [4:0] e_wa,
                              input logic [31:0] e_in, input logic [31:0] e_imm, input logic e_rden,
                              input logic [4:0] e_rda, input logic [31:0] e_rdd, input logic e_ill,
                              input logic [CW-1:0] e_cnt);
    vec_t x;
    x.v = v; x.t = t; x.a = a; x.r1a = r1a; x.r1d = r1d; x.z = z; x.rd = rd;
    x.e_ren = e_ren; x.e_ra = e_ra; x.e_wen = e_wen; x.e_wa = e_wa; x.e_in = e_in; x.e_imm = e_imm;
    x.e_rden = e_rden; x.e_rda = e_rda; x.e_rdd = e_rdd; x.e_ill = e_ill; x.e_cnt = e_cnt;
    return x;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " read_en"}, 32'(csr_read_en), 32'd0);
    chk({tag, " write_en"}, 32'(csr_write_en), 32'd0);
    chk({tag, " wb_rd_en"}, 32'(wb_rd_en), 32'd0);
    chk({tag, " wb_rd_data"}, wb_rd_data, 32'd0);
    chk({tag, " illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 32; i++) csr_file[i] = 32'(i) << 4;
    csr_file[3] = 32'h11;
    csr_file[4] = 32'h0;

    // Inputs apply before an edge; expectations hold just after it (EX = new op, WB = previous op).
    tbl[0]  = mk(1, W,    3, 5, 32'hDEADBEEF, 0,     7,  1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0,    0, 0, 0,            0,     0,  0, 0, 1, 3, 32'hDEADBEEF, 0, 1, 7, 32'h11, 0, 0);
    tbl[2]  = mk(1, S,    3, 0, 32'h123,      0,     8,  1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(1, CI,   3, 0, 0,            0,     9,  1, 3, 0, 3, 32'h123, 0, 1, 8, 32'hDEADBEEF, 0, 1);
    tbl[4]  = mk(1, WI,   5, 0, 0,            5'h1A, 0,  0, 5, 0, 3, 0, 0, 1, 9, 32'hDEADBEEF, 0, 2);
    tbl[5]  = mk(1, W,    4, 1, 32'hA,        0,     0,  0, 4, 1, 5, 0, 32'h1A, 0, 0, 0, 0, 3);
    tbl[6]  = mk(1, S,    4, 2, 32'h5,        0,     9,  1, 4, 1, 4, 32'hA, 0, 0, 0, 0, 0, 4);
    tbl[7]  = mk(0, 0,    0, 0, 0,            0,     0,  0, 0, 1, 4, 32'h5, 0, 1, 9, 32'hA, 0, 5);
    tbl[8]  = mk(1, 3'd4, 3, 1, 32'h99,       3,     10, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    tbl[9]  = mk(1, W,    0, 1, 32'h77,       0,     11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    tbl[10] = mk(0, 0,    0, 0, 0,            0,     0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    tbl[11] = mk(1, 3'd0, 3, 1, 32'h55,       0,     12, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    tbl[12] = mk(0, 0,    0, 0, 0,            0,     0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    tbl[13] = mk(0, 0,    0, 0, 0,            0,     0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);

    step();
    chk_zero("reset");
    chk("reset cnt", 32'(retired_cnt), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      set_id(tbl[i].v, tbl[i].t, tbl[i].a, tbl[i].r1a, tbl[i].r1d, tbl[i].z, tbl[i].rd);
      step();
      chk($sformatf("v%0d read_en", i),  32'(csr_read_en),  32'(tbl[i].e_ren));
      chk($sformatf("v%0d r_addr", i),   32'(csr_r_addr),   32'(tbl[i].e_ra));
      chk($sformatf("v%0d write_en", i), 32'(csr_write_en), 32'(tbl[i].e_wen));
      chk($sformatf("v%0d w_addr", i),   32'(csr_w_addr),   32'(tbl[i].e_wa));
      chk($sformatf("v%0d in_data", i),  csr_in_data,       tbl[i].e_in);
      chk($sformatf("v%0d imm", i),      csr_imm,           tbl[i].e_imm);
      chk($sformatf("v%0d rd_en", i),    32'(wb_rd_en),     32'(tbl[i].e_rden));
      chk($sformatf("v%0d rd_addr", i),  32'(wb_rd_addr),   32'(tbl[i].e_rda));
      chk($sformatf("v%0d rd_data", i),  wb_rd_data,        tbl[i].e_rdd);
      chk($sformatf("v%0d illegal", i),  32'(illegal),      32'(tbl[i].e_ill));
      chk($sformatf("v%0d cnt", i),      32'(retired_cnt),  32'(tbl[i].e_cnt));
    end
    chk("file[3]", csr_file[3], 32'hDEADBEEF);
    chk("file[4]", csr_file[4], 32'hF);
    chk("file[5]", csr_file[5], 32'h1A);
    chk("file[0] untouched", csr_file[0], 32'h0);

    // Stall three cycles with an op in EX, release, then flush the follower.
    w0 = n_writes;
    set_id(1, W, 6, 1, 32'h66, 0, 12);
    step();
    chk("stall pre r_addr", 32'(csr_r_addr), 32'd6);
    stall = 1'b1;
    set_id(1, W, 7, 1, 32'h77, 0, 13);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d read_en", i), 32'(csr_read_en), 32'd1);
      chk($sformatf("stall%0d r_addr", i), 32'(csr_r_addr), 32'd6);
      chk($sformatf("stall%0d write_en", i), 32'(csr_write_en), 32'd0);
    end
    stall = 1'b0;
    step();
    chk("release write_en", 32'(csr_write_en), 32'd1);
    chk("release w_addr", 32'(csr_w_addr), 32'd6);
    chk("release rd_addr", 32'(wb_rd_addr), 32'd12);
    chk("release rd_data", wb_rd_data, 32'h60);
    chk("release r_addr", 32'(csr_r_addr), 32'd7);
    flush = 1'b1;
    set_id(1, W, 8, 1, 32'h88, 0, 14);
    step();
    chk("flush read_en", 32'(csr_read_en), 32'd0);
    chk("flush write_en", 32'(csr_write_en), 32'd0);
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("post flush write_en", 32'(csr_write_en), 32'd0);
    chk("stall seq cnt", 32'(retired_cnt), 32'd7);
    chk("stall seq writes", 32'(n_writes - w0), 32'd1);
    chk("file[6]", csr_file[6], 32'h66);
    chk("file[7]", csr_file[7], 32'h70);
    chk("file[8]", csr_file[8], 32'h80);

    // flush and stall together leave a bubble.
    set_id(1, W, 9, 1, 32'h99, 0, 14);
    step();
    stall = 1'b1; flush = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("fs read_en", 32'(csr_read_en), 32'd0);
    chk("fs write_en", 32'(csr_write_en), 32'd0);
    stall = 1'b0; flush = 1'b0;
    step();
    chk("fs next write_en", 32'(csr_write_en), 32'd0);
    step();
    chk("file[9]", csr_file[9], 32'h90);
    chk("fs cnt", 32'(retired_cnt), 32'd7);

    // Reset in the middle of a WB cycle, before its falling-edge write.
    set_id(1, W, 10, 1, 32'hAA, 0, 15);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("pre rst write_en", 32'(csr_write_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_zero("mid rst");
    chk("mid rst cnt", 32'(retired_cnt), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post rst write_en", 32'(csr_write_en), 32'd0);
    chk("file[10]", csr_file[10], 32'hA0);

    // Counter wraps from all-ones back to zero.
    for (int i = 0; i < 15; i++) begin
      set_id(1, S, 1, 0, 0, 0, 0);
      step();
    end
    set_id(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("cnt all ones", 32'(retired_cnt), 32'hF);
    set_id(1, S, 1, 0, 0, 0, 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("cnt wrap", 32'(retired_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_ex_stage.md
Name: csr_ex_stage

Overview:
Pipeline stage between the decoder and the CSR register file. It latches decoded CSR instructions, drives the file's read port in EX and its write port in WB, and returns the old CSR value to the integer writeback path. It also applies RISC-V write/read suppression rules, flags illegal CSR ops and counts retired CSR instructions. The file writes on the falling clock edge, so a WB-stage write is visible to the EX-stage read before the next rising edge. No forwarding between back-to-back CSR ops is needed.

Parameters:
CNT_W, 32, width of retired-CSR-op counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
stall  in  1  hold EX register; bubble into WB
flush  in  1  kill EX-bound op; priority over stall
id_valid  in  1  decoder presents a CSR op
id_csr_type  in  3  op code from Parameters.v (CSRRW..CSRRCI)
id_csr_addr  in  5  CSR index 1..31
id_rs1_addr  in  5  rs1 index
id_rs1_data  in  32  rs1 value
id_zimm  in  5  immediate field
id_rd  in  5  destination register
csr_read_en  out  1  to file read_en
csr_r_addr  out  5  to file r_addr
csr_rdata  in  32  from file out_data
csr_write_en  out  1  to file write_en
csr_w_addr  out  5  to file w_addr
csr_type  out  3  to file csr_type
csr_in_data  out  32  to file in_data
csr_imm  out  32  to file imm
wb_rd_en  out  1  integer regfile write enable
wb_rd_addr  out  5  integer rd index
wb_rd_data  out  32  old CSR value
illegal  out  1  one-cycle illegal-CSR pulse in WB
retired_cnt  out  CNT_W  count of completed legal CSR ops

Behaviour:
- Reset (async, any time): EX/WB valid=0, all outputs 0, retired_cnt=0. An op in flight is dropped and no write is issued after rst deasserts.
- EX register update on rising edge:
  - flush=1: EX valid <= 0.
  - else stall=1: EX register holds.
  - else: capture all id_* fields, with EX valid <= id_valid.
- WB register update: captures EX contents every edge. WB valid <= EX valid & ~stall & ~flush.
- EX cycle, when EX valid:
  - csr_r_addr = EX csr_addr.
  - csr_read_en=1, except CSRRW/CSRRWI with rd=0 (read suppressed).
  - csr_rdata is latched into WB data at the next edge. This value includes any WB write made at this cycle's falling edge.
- WB cycle, when WB valid and legal:
  - csr_write_en=1, except:
    - CSRRS/CSRRC with rs1_addr=0;
    - CSRRSI/CSRRCI with zimm=0.
  - csr_w_addr=addr, csr_type=type, csr_in_data=rs1_data, csr_imm=zero-extended zimm.
  - wb_rd_en=1 iff rd!=0; wb_rd_addr=rd, wb_rd_data=latched old value (0 if read suppressed).
- Legal op: csr_type is one of the six defined codes and csr_addr!=0. Otherwise:
  - illegal=1 for that WB cycle;
  - no CSR write, no rd write, counter unchanged.
- Outputs with no valid op in a stage: enables 0, data/address outputs 0.
- retired_cnt increments by 1 per legal WB op and wraps from all-ones to 0.
- Stall with an op in EX: the read is re-driven each stalled cycle. Only the value captured on the releasing edge is used, and no duplicate WB occurs.

Test Plan:
- CSRRW addr 3, rs1 x5=0xDEADBEEF, rd x7, file[3]=0x11 -> EX read_en=1 r_addr=3; WB write_en=1, file[3]=0xDEADBEEF after negedge; x7 gets 0x11; retired_cnt=1.
- CSRRS addr 3 with rs1=0, then CSRRCI addr 3 with zimm=0 -> both write_en=0, file unchanged, rd gets current value; CSRRWI rd=0 -> read_en=0, wb_rd_en=0, write imm.
- Back-to-back CSRRW addr 4 (data 0xA) then CSRRS addr 4 (rs1 data 0x5, rd x9) -> x9 gets 0xA, file[4]=0xF.
- csr_type undefined code or addr 0 -> illegal pulses one cycle, no writes, counter unchanged.
- stall 3 cycles with CSRRW in EX, then flush with new op in ID -> exactly one WB for stalled op; flushed op never writes; flush+stall together -> bubble.
- rst asserted mid-cycle while op in WB -> outputs 0 immediately; no write after release; preload retired_cnt path to 0xFFFFFFFF -> next legal op wraps to 0.
